// File: rtl/iob_rom_sp_reader_pkg.sv
// ---------------------------------------------------------------------------
// iob_rom_sp_reader_pkg
// Shared definitions for the ROM block reader: the FSM state type, the
// output buffer depth and the width needed to hold a buffer fill level.
// ---------------------------------------------------------------------------
package iob_rom_sp_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned BUF_DEPTH = 2;
    // Holds 0..BUF_DEPTH inclusive.
    localparam int unsigned LVL_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/iob_rom_sp_reader_if.sv
// ---------------------------------------------------------------------------
// iob_rom_sp_reader_if
// Bus bundle of the ROM block reader: the single-port ROM read port
// (address/enable out, registered data back) and the valid/ready output
// stream with a last flag. Signal names keep the original port names.
//   master : the reader (drives ROM address/enable and the stream)
//   slave  : ROM + stream sink side
// ---------------------------------------------------------------------------
interface iob_rom_sp_reader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_en_o;
    logic [DATA_W-1:0] rom_r_data_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;

    modport master (
        output rom_addr_o,
        output rom_en_o,
        input  rom_r_data_i,
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  rom_addr_o,
        input  rom_en_o,
        output rom_r_data_i,
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/iob_rom_sp_reader_buf.sv
// ---------------------------------------------------------------------------
// iob_rom_sp_reader_buf
// Two-entry FIFO holding {last, data} words read back from the ROM.
// Push and pop may happen in the same cycle. The caller guarantees it never
// pushes into a full buffer without popping and never pops an empty one.
// Ports:
//   i_clk, i_arst    clock, asynchronous active-high reset
//   i_push           write i_push_data at the tail
//   i_push_data      word to write
//   i_pop            drop the head entry
//   o_level          number of stored entries (0..2)
//   o_head           head entry (0 after reset)
// ---------------------------------------------------------------------------
module iob_rom_sp_reader_buf
    import iob_rom_sp_reader_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    input  logic             i_pop,
    output logic [LVL_W-1:0] o_level,
    output logic [W-1:0]     o_head
);

    logic [W-1:0]     r_mem [BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/iob_rom_sp_reader.sv
// ---------------------------------------------------------------------------
// iob_rom_sp_reader
// Reads a block of consecutive words from a single-port ROM (1-cycle read
// latency) starting at a base address and streams them out on a valid/ready
// interface with a last flag. Reads are throttled by a credit count so the
// 2-entry output buffer can never overflow; back-pressure never loses or
// duplicates a word.
// Ports:
//   clk_i        clock
//   arst_i       asynchronous active-high reset
//   start_i      start pulse, sampled only in IDLE
//   base_addr_i  first ROM address, sampled with start_i
//   len_i        number of words, sampled with start_i (0 = empty transfer)
//   busy_o       transfer in progress (any state other than IDLE)
//   done_o       one-cycle completion pulse
//   bus          ROM read port + output stream (master side)
// ---------------------------------------------------------------------------
module iob_rom_sp_reader
    import iob_rom_sp_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    iob_rom_sp_reader_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [LVL_W-1:0]  w_level;
    logic [DATA_W:0]   w_head;
    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_credit;
    logic              w_rom_en;
    logic              w_final_read;

    assign w_valid = (w_level != '0);
    assign w_pop   = w_valid & bus.m_ready_i;

    // Free slots once this cycle's pop is taken into account. Buffered plus
    // in-flight words never exceed BUF_DEPTH, so this cannot underflow.
    assign w_credit = 3'(BUF_DEPTH)
                    - ({1'b0, w_level} + {2'b00, r_inflight})
                    + {2'b00, w_pop};

    assign w_rom_en     = (r_state == ST_RUN) && (r_remaining != '0) && (w_credit != '0);
    assign w_final_read = w_rom_en && (r_remaining == LEN_W'(1));

    // State register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_final_read) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the last word is accepted rather than one cycle
                // after, so done_o lands the cycle after the final handshake.
                if (!r_inflight &&
                    ((w_level == '0) || ((w_level == LVL_W'(1)) && w_pop))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address/length counters and the in-flight read tracker.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start_i) begin
                r_addr      <= base_addr_i;
                r_remaining <= len_i;
            end else if (w_rom_en) begin
                // Address wraps modulo 2**ADDR_W.
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
            r_inflight      <= w_rom_en;
            r_inflight_last <= w_final_read;
        end
    end

    iob_rom_sp_reader_buf #(
        .W (DATA_W + 1)
    ) u_buf (
        .i_clk       (clk_i),
        .i_arst      (arst_i),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.rom_r_data_i}),
        .i_pop       (w_pop),
        .o_level     (w_level),
        .o_head      (w_head)
    );

    assign bus.rom_en_o   = w_rom_en;
    assign bus.rom_addr_o = r_addr;
    assign bus.m_valid_o  = w_valid;
    assign bus.m_data_o   = w_head[DATA_W-1:0];
    assign bus.m_last_o   = w_head[DATA_W];

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = (r_state == ST_DONE);

endmodule
